map_upsert_sequencer: RTL and testbench
=======================================

Name: map_upsert_sequencer

Overview:
- Command front-end directly upstream of map_data_structure.
- Accepts host requests (UPSERT, DELETE, LOOKUP) over a valid/ready handshake.
- Expands each request into the primitive map op sequence: LOOKUP probe, optional DELETE, optional INSERT.
- Returns one status/value response per request, so the host never needs to know whether a key already exists.

Parameters:
KEY_WIDTH, 8, key width; must match the downstream map.
VALUE_WIDTH, 16, value width; must match the downstream map.
STAT_WIDTH, 16, width of each statistics counter (optional feature only).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  host request valid.
req_ready  output  1  request accepted when req_valid & req_ready at rising edge.
req_op  input  2  0 NOP, 1 UPSERT, 2 DELETE, 3 LOOKUP.
req_key  input  KEY_WIDTH  request key.
req_value  input  VALUE_WIDTH  request value (UPSERT only).
rsp_valid  output  1  response valid.
rsp_ready  input  1  host accepts response.
rsp_status  output  2  0 OK, 1 REPLACED, 2 NOT_FOUND, 3 FULL.
rsp_value  output  VALUE_WIDTH  LOOKUP hit value, else 0.
map_op  output  2  to map op; 0/1/2/3 encoding as in map.
map_key  output  KEY_WIDTH  to map key_in.
map_value  output  VALUE_WIDTH  to map value_in.
map_valid  output  1  to map valid_in.
map_ready  input  1  from map ready_out (map not full).
map_rsp_valid  input  1  from map valid_out (LOOKUP hit).
map_rsp_value  input  VALUE_WIDTH  from map value_out.
stat_ops, stat_hits, stat_full  output  STAT_WIDTH each  statistics (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; latched key/value/op cleared to 0.
  - rsp_valid=0, rsp_status=0, rsp_value=0.
  - map_op=NOP, map_valid=0, map_key=0, map_value=0; stat counters=0.
  - Reset mid-sequence abandons the sequence; no partial response.
- States: IDLE, PROBE, DEL, INS, RESP.
- req_ready=1 only in IDLE, decoded combinationally from state.
- IDLE:
  - On accept, latch op/key/value.
  - NOP: stay IDLE, no map traffic, no response.
  - Otherwise go to PROBE.
- PROBE (1 cycle):
  - Drive map_op=LOOKUP, map_valid=1, map_key=latched key.
  - At edge, sample hit=map_rsp_valid and value=map_rsp_value.
- Transitions out of PROBE:
  - LOOKUP: go RESP; status OK with value on hit, else NOT_FOUND with value 0.
  - DELETE: hit goes DEL; miss goes RESP with NOT_FOUND.
  - UPSERT hit: go DEL, then INS.
  - UPSERT miss with map_ready=1: go INS.
  - UPSERT miss with map_ready=0: go RESP with FULL; map unchanged.
- DEL (1 cycle):
  - Drive map_op=DELETE, map_valid=1, latched key.
  - Next state: INS if UPSERT; else RESP with OK.
- INS:
  - Drive map_op=INSERT, map_valid=1, latched key/value.
  - Leave when map_ready=1 at edge.
  - Next state RESP with status OK (new key) or REPLACED (came via DEL).
- RESP:
  - rsp_valid=1; status/value held stable until rsp_ready.
  - On the handshake edge go IDLE; req_ready rises the next cycle.
- Outside PROBE/DEL/INS: map_op=NOP, map_valid=0.
- All map_* and rsp_* outputs are registered or state-decoded; no combinational path from req_* to map_*.
- Latency from accept edge to rsp_valid:
  - LOOKUP, DELETE miss, UPSERT FULL: 2 cycles.
  - DELETE hit, UPSERT new: 3 cycles.
  - UPSERT replace: 4 cycles.
- Exactly one request in flight; throughput at most 1 request per 3 cycles.
- rsp_ready held low: FSM stalls in RESP indefinitely; req_ready stays 0.

Optional Feature:
- Macro MAP_UPSERT_STATS_EN.
- Defined:
  - stat_ops increments on each non-NOP request accept.
  - stat_hits increments on each PROBE with hit=1.
  - stat_full increments on each FULL response.
  - All counters saturate at all-ones, never wrap, and reset to 0.
- Undefined: counter logic is not compiled; stat_* outputs are tied to 0.

Test Plan:
- Reset, then UPSERT key 0x12 value 0xBEEF on an empty map -> map sees LOOKUP then INSERT; rsp OK, rsp_value 0; rsp_valid 3 cycles after accept.
- LOOKUP 0x12 -> rsp OK with value 0xBEEF at +2 cycles; LOOKUP 0x34 -> NOT_FOUND, value 0.
- UPSERT 0x12 with 0x1234 -> LOOKUP, DELETE, INSERT sequence; rsp REPLACED at +4; subsequent LOOKUP returns 0x1234.
- Fill a 16-entry map with keys 0x00..0x0F, then UPSERT 0x40 -> rsp FULL at +2, no INSERT issued; then UPSERT 0x05 -> REPLACED.
- DELETE 0x12 -> OK with DELETE issued; DELETE 0x12 again -> NOT_FOUND, no DELETE issued.
- Hold rsp_ready=0 for 10 cycles -> rsp stable, req_ready 0. Assert reset_n=0 mid-INS -> all outputs 0 immediately, FSM IDLE; with MAP_UPSERT_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/map_upsert_sequencer.sv
// Command front-end for map_data_structure: expands UPSERT/DELETE/LOOKUP into LOOKUP/DELETE/INSERT primitives.
// Optional saturating statistics counters are compiled in when MAP_UPSERT_STATS_EN is defined.
module map_upsert_sequencer #(
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 16,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_status,
  output logic [VALUE_WIDTH-1:0] rsp_value,
  output logic [1:0]             map_op,
  output logic [KEY_WIDTH-1:0]   map_key,
  output logic [VALUE_WIDTH-1:0] map_value,
  output logic                   map_valid,
  input  logic                   map_ready,
  input  logic                   map_rsp_valid,
  input  logic [VALUE_WIDTH-1:0] map_rsp_value,
  output logic [STAT_WIDTH-1:0]  stat_ops,
  output logic [STAT_WIDTH-1:0]  stat_hits,
  output logic [STAT_WIDTH-1:0]  stat_full,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_PROBE, S_DEL, S_INS, S_RESP} state_t;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_UPSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_LOOKUP = 2'd3;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_REPLACED  = 2'd1;
  localparam logic [1:0] ST_NOT_FOUND = 2'd2;
  localparam logic [1:0] ST_FULL      = 2'd3;

  state_t                 state_q, state_d;
  logic [1:0]             op_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] value_q;
  logic                   replace_q;
  logic [1:0]             status_q, status_d;
  logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;
  logic                   rsp_load;
  logic                   accept;
  logic                   full_rsp;

  // Handshakes: a transfer happens on the rising edge where valid & ready are both 1;
  // valid never waits on ready, and payload stays stable while valid is high.
  assign accept    = req_valid & req_ready;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    rsp_load = 1'b0;
    status_d = ST_OK;
    rvalue_d = '0;
    case (state_q)
      S_IDLE: if (accept && req_op != OP_NOP) state_d = S_PROBE;
      S_PROBE: begin
        case (op_q)
          OP_LOOKUP: begin
            state_d  = S_RESP;
            rsp_load = 1'b1;
            status_d = map_rsp_valid ? ST_OK : ST_NOT_FOUND;
            rvalue_d = map_rsp_valid ? map_rsp_value : '0;
          end
          OP_DELETE: begin
            if (map_rsp_valid) begin
              state_d = S_DEL;
            end else begin
              state_d  = S_RESP;
              rsp_load = 1'b1;
              status_d = ST_NOT_FOUND;
            end
          end
          default: begin
            if (map_rsp_valid) begin
              state_d = S_DEL;
            end else if (map_ready) begin
              state_d = S_INS;
            end else begin
              state_d  = S_RESP;
              rsp_load = 1'b1;
              status_d = ST_FULL;
            end
          end
        endcase
      end
      S_DEL: begin
        if (op_q == OP_UPSERT) begin
          state_d = S_INS;
        end else begin
          state_d  = S_RESP;
          rsp_load = 1'b1;
          status_d = ST_OK;
        end
      end
      S_INS: begin
        if (map_ready) begin
          state_d  = S_RESP;
          rsp_load = 1'b1;
          status_d = replace_q ? ST_REPLACED : ST_OK;
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      key_q     <= '0;
      value_q   <= '0;
      replace_q <= 1'b0;
      status_q  <= ST_OK;
      rvalue_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= req_op;
        key_q     <= req_key;
        value_q   <= req_value;
        replace_q <= 1'b0;
      end else if (state_q == S_DEL) begin
        replace_q <= 1'b1;
      end
      if (rsp_load) begin
        status_q <= status_d;
        rvalue_q <= rvalue_d;
      end
    end
  end

  assign rsp_status = status_q;
  assign rsp_value  = rvalue_q;
  assign map_valid  = (state_q == S_PROBE) || (state_q == S_DEL) || (state_q == S_INS);
  assign map_op     = (state_q == S_PROBE) ? OP_LOOKUP :
                      (state_q == S_DEL)   ? OP_DELETE :
                      (state_q == S_INS)   ? OP_UPSERT : OP_NOP;
  assign map_key    = key_q;
  assign map_value  = value_q;
  assign full_rsp   = rsp_load && (status_d == ST_FULL);

`ifdef MAP_UPSERT_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;
  logic [STAT_WIDTH-1:0] ops_q, hits_q, full_q;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ops_q  <= '0;
      hits_q <= '0;
      full_q <= '0;
    end else begin
      if (accept && req_op != OP_NOP && ops_q != '1) ops_q <= ops_q + STAT_ONE;
      if (state_q == S_PROBE && map_rsp_valid && hits_q != '1) hits_q <= hits_q + STAT_ONE;
      if (full_rsp && full_q != '1) full_q <= full_q + STAT_ONE;
    end
  end

  assign stat_ops  = ops_q;
  assign stat_hits = hits_q;
  assign stat_full = full_q;
`else
  logic unused_full;
  assign unused_full = full_rsp;
  assign stat_ops    = '0;
  assign stat_hits   = '0;
  assign stat_full   = '0;
`endif

endmodule

// File: tb/tb_map_upsert_sequencer.sv
// Bench for map_upsert_sequencer: behavioural 16-entry map device, directed vector table,
// hand-written stall/reset sequences and randomized requests against an associative-array model.
module tb_map_upsert_sequencer;
  localparam int KW = 8;
  localparam int VW = 16;
  localparam int SW = 16;
  localparam int DEPTH = 16;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_UPS = 2'd1;
  localparam logic [1:0] OP_DEL = 2'd2;
  localparam logic [1:0] OP_LKP = 2'd3;
  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_REP  = 2'd1;
  localparam logic [1:0] ST_NF   = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]    req_op, rsp_status, map_op;
  logic [KW-1:0] req_key, map_key;
  logic [VW-1:0] req_value, rsp_value, map_value, map_rsp_value;
  logic          map_valid, map_ready, map_rsp_valid;
  logic [SW-1:0] stat_ops, stat_hits, stat_full;
  logic [2:0]    dbg_state;

  map_upsert_sequencer #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_value(rsp_value),
    .map_op(map_op), .map_key(map_key), .map_value(map_value), .map_valid(map_valid),
    .map_ready(map_ready), .map_rsp_valid(map_rsp_valid), .map_rsp_value(map_rsp_value),
    .stat_ops(stat_ops), .stat_hits(stat_hits), .stat_full(stat_full), .dbg_state(dbg_state)
  );

  // ---------------- downstream map device ----------------
  logic          dev_present [256] = '{default: 1'b0};
  logic [VW-1:0] dev_val     [256] = '{default: '0};
  int            dev_cnt = 0;
  logic          dev_clear = 1'b0;

  assign map_ready     = (dev_cnt < DEPTH);
  assign map_rsp_valid = map_valid && (map_op == OP_LKP) && dev_present[map_key];
  assign map_rsp_value = map_rsp_valid ? dev_val[map_key] : '0;

  always @(posedge clk) begin
    if (dev_clear) begin
      for (int i = 0; i < 256; i++) dev_present[i] <= 1'b0;
      dev_cnt <= 0;
    end else if (map_valid) begin
      if (map_op == OP_DEL && dev_present[map_key]) begin
        dev_present[map_key] <= 1'b0;
        dev_cnt <= dev_cnt - 1;
      end else if (map_op == OP_UPS && map_ready && !dev_present[map_key]) begin
        dev_present[map_key] <= 1'b1;
        dev_val[map_key] <= map_value;
        dev_cnt <= dev_cnt + 1;
      end
    end
  end

  // ---------------- map-traffic monitor ----------------
  typedef struct packed {
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
  } mop_t;
  mop_t op_log[$];

  always @(negedge clk) begin
    if (reset_n && map_valid) op_log.push_back(mop_t'({map_op, map_key, map_value}));
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [VW-1:0] ref_map[bit [KW-1:0]];
  int exp_ops = 0;
  int exp_hits = 0;
  int exp_full = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Latency is counted in edges from the accept edge to the first edge that samples rsp_valid=1.
  task automatic run_req(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                         output logic [1:0] st, output logic [VW-1:0] v, output int lat, output int nops);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_ready_idle", req_ready, 1);
    op_log.delete();
    req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = OP_NOP;
    req_key = KW'($urandom); req_value = VW'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
    st = rsp_status;
    v = rsp_value;
    @(posedge clk); #1;
    nops = op_log.size();
  endtask

  task automatic model_req(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
    logic [1:0]    est, st;
    logic [VW-1:0] ev, v;
    int            elat, lat, nops;
    logic          hit;
    mop_t          eops[$];
    mop_t          a, e;
    hit = ref_map.exists(key);
    ev = '0;
    eops.push_back(mop_t'({OP_LKP, key, VW'(0)}));
    exp_ops++;
    if (hit) exp_hits++;
    case (op)
      OP_LKP: begin
        elat = 2;
        if (hit) begin est = ST_OK; ev = ref_map[key]; end
        else est = ST_NF;
      end
      OP_DEL: begin
        if (hit) begin
          eops.push_back(mop_t'({OP_DEL, key, VW'(0)}));
          ref_map.delete(key);
          est = ST_OK; elat = 3;
        end else begin
          est = ST_NF; elat = 2;
        end
      end
      default: begin
        if (hit) begin
          eops.push_back(mop_t'({OP_DEL, key, VW'(0)}));
          eops.push_back(mop_t'({OP_UPS, key, val}));
          ref_map[key] = val;
          est = ST_REP; elat = 4;
        end else if (ref_map.num() < DEPTH) begin
          eops.push_back(mop_t'({OP_UPS, key, val}));
          ref_map[key] = val;
          est = ST_OK; elat = 3;
        end else begin
          est = ST_FULL; elat = 2;
          exp_full++;
        end
      end
    endcase
    run_req(op, key, val, st, v, lat, nops);
    check("model_status", st, est);
    check("model_value", v, ev);
    check("model_latency", lat, elat);
    check("model_map_op_count", nops, eops.size());
    for (int i = 0; i < eops.size() && i < op_log.size(); i++) begin
      a = op_log[i];
      e = eops[i];
      check("model_map_op_key", {a.op, a.key}, {e.op, e.key});
      if (e.op == OP_UPS) check("model_map_ins_value", a.val, e.val);
    end
  endtask

  task automatic nop_check(input logic [KW-1:0] key);
    op_log.delete();
    req_valid = 1'b1; req_op = OP_NOP; req_key = key;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("nop_req_ready", req_ready, 1);
    check("nop_no_rsp", rsp_valid, 0);
    check("nop_no_map_traffic", op_log.size(), 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef MAP_UPSERT_STATS_EN
    check({tag, "_stat_ops"}, stat_ops, exp_ops);
    check({tag, "_stat_hits"}, stat_hits, exp_hits);
    check({tag, "_stat_full"}, stat_full, exp_full);
`else
    check({tag, "_stat_ops"}, stat_ops, 0);
    check({tag, "_stat_hits"}, stat_hits, 0);
    check({tag, "_stat_full"}, stat_full, 0);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
    logic [1:0]    st;
    logic [VW-1:0] v;
    int            lat;
    int            nops;
    logic          hit;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic [1:0]    st, s0;
    logic [VW-1:0] v, v0;
    int            lat, nops, guard;

    tbl[0] = '{OP_UPS, 8'h12, 16'hBEEF, ST_OK,  16'h0000, 3, 2, 1'b0};
    tbl[1] = '{OP_LKP, 8'h12, 16'h0000, ST_OK,  16'hBEEF, 2, 1, 1'b1};
    tbl[2] = '{OP_LKP, 8'h34, 16'h0000, ST_NF,  16'h0000, 2, 1, 1'b0};
    tbl[3] = '{OP_UPS, 8'h12, 16'h1234, ST_REP, 16'h0000, 4, 3, 1'b1};
    tbl[4] = '{OP_LKP, 8'h12, 16'h0000, ST_OK,  16'h1234, 2, 1, 1'b1};
    tbl[5] = '{OP_DEL, 8'h12, 16'h0000, ST_OK,  16'h0000, 3, 2, 1'b1};
    tbl[6] = '{OP_DEL, 8'h12, 16'h0000, ST_NF,  16'h0000, 2, 1, 1'b0};

    req_valid = 1'b0; req_op = OP_NOP; req_key = '0; req_value = '0; rsp_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_value", rsp_value, 0);
    check("rst_map_valid", map_valid, 0);
    check("rst_map_op", map_op, 0);
    check("rst_map_key", map_key, 0);
    check("rst_map_value", map_value, 0);
    check_stats("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_req(tbl[i].op, tbl[i].key, tbl[i].val, st, v, lat, nops);
      check("tbl_status", st, tbl[i].st);
      check("tbl_value", v, tbl[i].v);
      check("tbl_latency", lat, tbl[i].lat);
      check("tbl_map_op_count", nops, tbl[i].nops);
      exp_ops++;
      if (tbl[i].hit) exp_hits++;
    end

    nop_check(8'h55);

    // fill the map to capacity, then overflow and replace
    for (int k = 0; k < DEPTH; k++) model_req(OP_UPS, KW'(k), VW'($urandom));
    model_req(OP_UPS, 8'h40, 16'hAAAA);
    check("full_no_entry_added", dev_present[8'h40], 0);
    model_req(OP_UPS, 8'h05, 16'h5555);
    check("replace_when_full_value", dev_val[8'h05], 16'h5555);

    // response back-pressure: rsp held stable, no new request accepted
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = OP_LKP; req_key = 8'h05;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = OP_NOP;
    exp_ops++; exp_hits++;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    s0 = rsp_status;
    v0 = rsp_value;
    check("stall_status", s0, ST_OK);
    check("stall_value", v0, 16'h5555);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_req_ready", req_ready, 0);
      check("stall_status_stable", rsp_status, s0);
      check("stall_value_stable", rsp_value, v0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_rsp_valid", rsp_valid, 0);
    check("stall_release_req_ready", req_ready, 1);

    // randomized traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      logic [1:0] rop;
      rop = 2'($urandom_range(0, 3));
      if (rop == OP_NOP) nop_check(KW'($urandom));
      else model_req(rop, KW'($urandom_range(0, 23)), VW'($urandom));
    end
    check_stats("run");

    // reset in the middle of an INSERT
    dev_clear = 1'b1;
    @(posedge clk); #1;
    dev_clear = 1'b0;
    ref_map.delete();
    req_valid = 1'b1; req_op = OP_UPS; req_key = 8'h77; req_value = 16'h7777;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = OP_NOP;
    check("mid_probe_op", map_op, OP_LKP);
    @(posedge clk); #1;
    check("mid_ins_op", map_op, OP_UPS);
    check("mid_ins_valid", map_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_map_valid", map_valid, 0);
    check("arst_map_op", map_op, 0);
    check("arst_map_key", map_key, 0);
    check("arst_map_value", map_value, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_status", rsp_status, 0);
    check("arst_rsp_value", rsp_value, 0);
    check("arst_req_ready", req_ready, 1);
    exp_ops = 0; exp_hits = 0; exp_full = 0;
    check_stats("arst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_no_insert", dev_present[8'h77], 0);
    check("arst_no_rsp", rsp_valid, 0);
    model_req(OP_LKP, 8'h77, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
